// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronises and glitch-filters A/B, decodes
// Gray-code steps into a hold/inc/dec command and tracks illegal double-edge transitions.
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter bit DIR_INV     = 1'b0,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en,
  input  logic             err_clr,
  output logic [1:0]       ctrl,
  output logic             dir,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int SCW = $clog2(SYNC_STAGES + FILT_LEN);
  localparam logic [1:0] INC_CODE = DIR_INV ? 2'b10 : 2'b01;
  localparam logic [1:0] DEC_CODE = DIR_INV ? 2'b01 : 2'b10;
  localparam logic       FWD_DIR  = DIR_INV;

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state;
  logic [SCW-1:0]         start_cnt;
  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [1:0]             syn, filt, filt_nxt, prev;
  logic [FCW-1:0]         cnt [2];
  logic [FCW-1:0]         cnt_nxt [2];
  logic [1:0]             delta;
  logic                   illegal;

  assign syn = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  // Bit 1 is channel A, bit 0 is channel B throughout.
  always_comb begin
    filt_nxt = filt;
    cnt_nxt  = '{default: '0};
    for (int ch = 0; ch < 2; ch++) begin
      if (syn[ch] != filt[ch]) begin
        if (cnt[ch] == FCW'(FILT_LEN - 1)) filt_nxt[ch] = syn[ch];
        else cnt_nxt[ch] = cnt[ch] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      filt   <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], a_in};
      sync_b <= {sync_b[SYNC_STAGES-2:0], b_in};
      filt   <= filt_nxt;
      cnt[0] <= cnt_nxt[0];
      cnt[1] <= cnt_nxt[1];
    end
  end

  // Gray code to position: forward motion walks 0,1,2,3 modulo 4.
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  assign delta   = gray_pos(filt) - gray_pos(prev);
  assign illegal = (state == RUN) && en && (delta == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      start_cnt <= '0;
      prev      <= '0;
      ctrl      <= 2'b00;
      dir       <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      ctrl <= 2'b00;
      case (state)
        INIT: begin
          // Track the value the filter is about to hold so RUN starts with no phantom step.
          prev <= filt_nxt;
          if (start_cnt == SCW'(SYNC_STAGES + FILT_LEN - 1)) state <= RUN;
          else start_cnt <= start_cnt + 1'b1;
        end
        RUN: begin
          prev <= filt;
          if (en) begin
            if (delta == 2'd1) begin
              ctrl <= INC_CODE;
              dir  <= FWD_DIR;
            end else if (delta == 2'd3) begin
              ctrl <= DEC_CODE;
              dir  <= ~FWD_DIR;
            end
          end
        end
        default: state <= INIT;
      endcase

      if (illegal) begin
        err <= 1'b1;
        if (err_clr) err_cnt <= ERR_W'(1);
        else if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
      end else if (err_clr) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: a normal and a DIR_INV instance share stimulus;
// expected pulses (cycle, ctrl, dir) are queued at drive time and popped when ctrl fires.
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       rst, a_in, b_in, en, err_clr;
  logic [1:0] ctrl, ctrl_i;
  logic       dir, dir_i, err, err_i;
  logic [7:0] err_cnt, err_cnt_i;

  quad_step_decoder #(.SYNC_STAGES(2), .FILT_LEN(4), .DIR_INV(1'b0), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .en(en), .err_clr(err_clr),
    .ctrl(ctrl), .dir(dir), .err(err), .err_cnt(err_cnt)
  );

  quad_step_decoder #(.SYNC_STAGES(2), .FILT_LEN(4), .DIR_INV(1'b1), .ERR_W(8)) dut_inv (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .en(en), .err_clr(err_clr),
    .ctrl(ctrl_i), .dir(dir_i), .err(err_i), .err_cnt(err_cnt_i)
  );

  // Clock and cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Entry layout: {cycle[31:0], ctrl[1:0], dir}
  logic [34:0] exp_q[$];
  logic [34:0] exp_inv_q[$];
  logic [34:0] mon_e, mon_ei;

  logic [1:0] cur_ab;
  logic       exp_en;
  logic       exp_err;
  logic [7:0] exp_cnt;

  // Scoreboard: every non-hold ctrl cycle must match the head of its queue.
  always @(negedge clk) begin
    if (ctrl !== 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: ctrl=%b dir=%b at cycle %0d, required no pulse", ctrl, dir, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if ({32'(cyc), ctrl, dir} !== mon_e) begin
          errors++;
          $display("FAIL pulse: cycle=%0d ctrl=%b dir=%b, required cycle=%0d ctrl=%b dir=%b",
                   cyc, ctrl, dir, mon_e[34:3], mon_e[2:1], mon_e[0]);
        end
      end
    end
    if (ctrl_i !== 2'b00) begin
      checks++;
      if (exp_inv_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse_inv: ctrl=%b dir=%b at cycle %0d, required no pulse", ctrl_i, dir_i, cyc);
      end else begin
        mon_ei = exp_inv_q.pop_front();
        if ({32'(cyc), ctrl_i, dir_i} !== mon_ei) begin
          errors++;
          $display("FAIL pulse_inv: cycle=%0d ctrl=%b dir=%b, required cycle=%0d ctrl=%b dir=%b",
                   cyc, ctrl_i, dir_i, mon_ei[34:3], mon_ei[2:1], mon_ei[0]);
        end
      end
    end
  end

  // Driver: change A/B, queue the expected response, then hold.
  task automatic step(input logic [1:0] ab, input int hold);
    logic fwd, rev, ill;
    @(negedge clk);
    fwd = (cur_ab == 2'b00 && ab == 2'b01) || (cur_ab == 2'b01 && ab == 2'b11) ||
          (cur_ab == 2'b11 && ab == 2'b10) || (cur_ab == 2'b10 && ab == 2'b00);
    rev = (cur_ab == 2'b01 && ab == 2'b00) || (cur_ab == 2'b11 && ab == 2'b01) ||
          (cur_ab == 2'b10 && ab == 2'b11) || (cur_ab == 2'b00 && ab == 2'b10);
    ill = ((cur_ab ^ ab) == 2'b11);
    a_in = ab[1];
    b_in = ab[0];
    if (exp_en) begin
      if (fwd) begin
        exp_q.push_back({32'(cyc + 7), 2'b01, 1'b0});
        exp_inv_q.push_back({32'(cyc + 7), 2'b10, 1'b1});
      end
      if (rev) begin
        exp_q.push_back({32'(cyc + 7), 2'b10, 1'b1});
        exp_inv_q.push_back({32'(cyc + 7), 2'b01, 1'b0});
      end
      if (ill) begin
        exp_err = 1'b1;
        exp_cnt = (exp_cnt == 8'hff) ? 8'hff : exp_cnt + 8'd1;
      end
    end
    cur_ab = ab;
    repeat (hold) @(negedge clk);
  endtask

  // Bounded wait for the scoreboard queues to empty.
  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || exp_inv_q.size() != 0); i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; a_in = 1'b0; b_in = 1'b0; en = 1'b1; err_clr = 1'b0;
    cur_ab = 2'b00; exp_en = 1'b1; exp_err = 1'b0; exp_cnt = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ctrl, dir, err, err_cnt, ctrl_i, dir_i, err_i, err_cnt_i} !== '0) begin
      errors++;
      $display("FAIL reset_values: %b %b %b %h / %b %b %b %h, required all zero",
               ctrl, dir, err, err_cnt, ctrl_i, dir_i, err_i, err_cnt_i);
    end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if ({err, err_cnt, err_i, err_cnt_i} !== '0) begin
      errors++;
      $display("FAIL init_err: err=%b cnt=%0d, required 0 0", err, err_cnt);
    end
  endtask

  task automatic test_forward();
    step(2'b01, 20); step(2'b11, 20); step(2'b10, 20); step(2'b00, 20);
    drain();
    checks++;
    if (exp_q.size() != 0 || exp_inv_q.size() != 0) begin
      errors++;
      $display("FAIL forward_missing: %0d/%0d pulses outstanding, required 0", exp_q.size(), exp_inv_q.size());
    end
    checks++;
    if ({dir, dir_i, err, err_i} !== 4'b0100) begin
      errors++;
      $display("FAIL forward_dir: dir=%b dir_inv=%b err=%b, required 0 1 0", dir, dir_i, err);
    end
  endtask

  task automatic test_reverse();
    step(2'b10, 20); step(2'b11, 20); step(2'b01, 20); step(2'b00, 20);
    drain();
    checks++;
    if (exp_q.size() != 0 || exp_inv_q.size() != 0) begin
      errors++;
      $display("FAIL reverse_missing: %0d/%0d pulses outstanding, required 0", exp_q.size(), exp_inv_q.size());
    end
    checks++;
    if ({dir, dir_i, err, err_i} !== 4'b1000) begin
      errors++;
      $display("FAIL reverse_dir: dir=%b dir_inv=%b err=%b, required 1 0 0", dir, dir_i, err);
    end
  endtask

  task automatic test_glitch();
    step(2'b01, 20);
    @(negedge clk);
    a_in = 1'b1;
    repeat (3) @(negedge clk);
    a_in = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (dut.filt !== 2'b01) begin
      errors++;
      $display("FAIL glitch_filt: filt=%b, required 01", dut.filt);
    end
    step(2'b11, 4);
    step(2'b01, 20);
    step(2'b00, 20);
    drain();
    checks++;
    if (exp_q.size() != 0 || exp_inv_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_missing: %0d/%0d pulses outstanding, required 0", exp_q.size(), exp_inv_q.size());
    end
  endtask

  task automatic test_back_to_back();
    step(2'b01, 1);
    step(2'b11, 20);
    step(2'b10, 1);
    step(2'b00, 20);
    drain();
    checks++;
    if (exp_q.size() != 0 || exp_inv_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing: %0d/%0d pulses outstanding, required 0", exp_q.size(), exp_inv_q.size());
    end
  endtask

  task automatic test_illegal();
    int c;
    step(2'b11, 10);
    checks++;
    if ({err, err_cnt, err_i, err_cnt_i} !== {exp_err, exp_cnt, exp_err, exp_cnt}) begin
      errors++;
      $display("FAIL illegal_first: err=%b cnt=%0d, required %b %0d", err, err_cnt, exp_err, exp_cnt);
    end
    for (int i = 1; i < 300; i++) step(~cur_ab, 8);
    checks++;
    if ({err, err_cnt, err_i, err_cnt_i} !== {1'b1, 8'hff, 1'b1, 8'hff} || exp_cnt !== 8'hff) begin
      errors++;
      $display("FAIL illegal_sat: err=%b cnt=%0d, required 1 255", err, err_cnt);
    end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0; exp_cnt = 8'd0;
    checks++;
    if ({err, err_cnt, err_i, err_cnt_i} !== '0) begin
      errors++;
      $display("FAIL err_clr: err=%b cnt=%0d, required 0 0", err, err_cnt);
    end
    step(~cur_ab, 10);
    step(~cur_ab, 10);
    checks++;
    if ({err, err_cnt} !== {1'b1, 8'd2}) begin
      errors++;
      $display("FAIL illegal_two: err=%b cnt=%0d, required 1 2", err, err_cnt);
    end
    // err_clr lands on the same edge the illegal transition is decoded.
    @(negedge clk);
    c = cyc;
    a_in = ~cur_ab[1];
    b_in = ~cur_ab[0];
    cur_ab = ~cur_ab;
    exp_err = 1'b1; exp_cnt = 8'd1;
    while (cyc < c + 6) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({err, err_cnt, err_i, err_cnt_i} !== {exp_err, exp_cnt, exp_err, exp_cnt}) begin
      errors++;
      $display("FAIL clr_vs_illegal: err=%b cnt=%0d, required 1 1", err, err_cnt);
    end
  endtask

  task automatic test_enable();
    step(2'b10, 20);
    step(2'b00, 20);
    @(negedge clk);
    en = 1'b0; exp_en = 1'b0;
    step(2'b01, 20); step(2'b11, 20); step(2'b00, 20); step(2'b11, 20);
    @(negedge clk);
    en = 1'b1; exp_en = 1'b1;
    repeat (20) @(negedge clk);
    step(2'b10, 20);
    drain();
    checks++;
    if (exp_q.size() != 0 || exp_inv_q.size() != 0) begin
      errors++;
      $display("FAIL enable_missing: %0d/%0d pulses outstanding, required 0", exp_q.size(), exp_inv_q.size());
    end
    checks++;
    if ({err, err_cnt} !== {exp_err, exp_cnt}) begin
      errors++;
      $display("FAIL enable_err: err=%b cnt=%0d, required %b %0d", err, err_cnt, exp_err, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    step(2'b11, 20);
    drain();
    @(negedge clk);
    a_in = 1'b1; b_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    a_in = 1'b1; b_in = 1'b1;
    exp_err = 1'b0; exp_cnt = 8'd0;
    checks++;
    if ({ctrl, dir, err, err_cnt, ctrl_i, err_i, err_cnt_i} !== '0) begin
      errors++;
      $display("FAIL mid_reset: ctrl=%b dir=%b err=%b cnt=%0d, required all zero", ctrl, dir, err, err_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if ({err, err_cnt, err_i, err_cnt_i} !== '0) begin
      errors++;
      $display("FAIL post_reset_err: err=%b cnt=%0d, required 0 0", err, err_cnt);
    end
    step(2'b10, 20);
    drain();
    checks++;
    if (exp_q.size() != 0 || exp_inv_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_missing: %0d/%0d pulses outstanding, required 0", exp_q.size(), exp_inv_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_back_to_back();
    test_illegal();
    test_enable();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
